// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and output-stage state encoding for the FIFO controller.
package fifo_ctrl_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_VALID = 1'b1
    } out_state_t;

endpackage

// File: rtl/memory.sv
// Simple dual-port RAM: synchronous write, registered read that holds r_data
// whenever r_en is low.
module memory #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              w_en,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [ADDR_W-1:0] r_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] r_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= w_data;
        end
        if (r_en) begin
            r_data <= mem[r_addr];
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Valid/ready FIFO controller around a block RAM with a one-word output stage.
// Optional almost_full/almost_empty flags are built when FIFO_CTRL_ALMOST_EN is defined.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   level
`ifdef FIFO_CTRL_ALMOST_EN
    ,
    output logic              almost_full,
    output logic              almost_empty
`endif
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(2 ** ADDR_W);

    logic [ADDR_W-1:0] wp_reg;
    logic [ADDR_W-1:0] rp_reg;
    logic [ADDR_W:0]   mem_cnt_reg;
    logic [ADDR_W:0]   mem_cnt_next;
    logic [ADDR_W:0]   level_reg;
    logic [ADDR_W:0]   level_next;
    out_state_t        state_reg;
    out_state_t        state_next;
    logic              wr_fire;
    logic              rd_fire;
    logic              issue;

    // wr_ready depends on registered occupancy only, never on rd_ready.
    assign wr_ready = (mem_cnt_reg != DEPTH_CNT);
    assign rd_valid = (state_reg == ST_VALID);
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_fire  = rd_valid && rd_ready;
    assign issue    = (mem_cnt_reg != '0) && (!rd_valid || rd_fire);
    assign level    = level_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: if (issue) state_next = ST_VALID;
            ST_VALID: if (rd_fire && !issue) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
    end

    always_comb begin
        mem_cnt_next = mem_cnt_reg;
        case ({wr_fire, issue})
            2'b10:   mem_cnt_next = mem_cnt_reg + 1'b1;
            2'b01:   mem_cnt_next = mem_cnt_reg - 1'b1;
            default: mem_cnt_next = mem_cnt_reg;
        endcase
        level_next = mem_cnt_next + {{ADDR_W{1'b0}}, (state_next == ST_VALID)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_reg      <= '0;
            rp_reg      <= '0;
            mem_cnt_reg <= '0;
            level_reg   <= '0;
            state_reg   <= ST_EMPTY;
        end else begin
            if (wr_fire) wp_reg <= wp_reg + 1'b1;
            if (issue)   rp_reg <= rp_reg + 1'b1;
            mem_cnt_reg <= mem_cnt_next;
            level_reg   <= level_next;
            state_reg   <= state_next;
        end
    end

`ifdef FIFO_CTRL_ALMOST_EN
    localparam logic [ADDR_W:0] AF_LVL = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_LVL = (ADDR_W+1)'(AE_LEVEL);

    logic almost_full_reg;
    logic almost_empty_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full_reg  <= 1'b0;
            almost_empty_reg <= 1'b1;
        end else begin
            almost_full_reg  <= (level_next >= AF_LVL);
            almost_empty_reg <= (level_next <= AE_LVL);
        end
    end

    assign almost_full  = almost_full_reg;
    assign almost_empty = almost_empty_reg;
`endif

    // Reads only target slots written on an earlier edge, so no collision handling.
    memory #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk    (clk),
        .w_en   (wr_fire),
        .r_en   (issue),
        .w_addr (wp_reg),
        .r_addr (rp_reg),
        .w_data (wr_data),
        .r_data (rd_data)
    );

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed plus randomized bench for fifo_ctrl against a queue-based reference model.
module tb_fifo_ctrl;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       rd_ready = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [4:0] level;
`ifdef FIFO_CTRL_ALMOST_EN
    logic       almost_full;
    logic       almost_empty;
`endif

    always #5 clk = ~clk;

    fifo_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .level        (level)
`ifdef FIFO_CTRL_ALMOST_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: words waiting in RAM, plus the single presented head word.
    int mq[$];
    bit m_ov = 1'b0;
    int m_word = 0;
    int sent[$];
    int rcvd[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_level();
        return mq.size() + int'(m_ov);
    endfunction

    task automatic check_outputs();
        chk("wr_ready", wr_ready, mq.size() != DEPTH);
        chk("rd_valid", rd_valid, m_ov);
        chk("level", level, m_level());
        if (m_ov) chk("rd_data", rd_data, m_word);
`ifdef FIFO_CTRL_ALMOST_EN
        chk("almost_full", almost_full, m_level() >= 12);
        chk("almost_empty", almost_empty, m_level() <= 2);
`endif
    endtask

    task automatic model_reset();
        mq.delete();
        m_ov = 1'b0;
        sent.delete();
        rcvd.delete();
    endtask

    // One clock: predict from the handshake rules, advance, check at negedge.
    task automatic cycle();
        bit wf, rf, iss;
        wf  = wr_valid && (mq.size() != DEPTH);
        rf  = m_ov && rd_ready;
        iss = (mq.size() != 0) && (!m_ov || rf);
        if (rd_valid && rd_ready) rcvd.push_back(int'(rd_data));
        if (wf) sent.push_back(int'(wr_data));
        @(posedge clk);
        if (iss) begin
            m_word = mq.pop_front();
            m_ov   = 1'b1;
        end else if (rf) begin
            m_ov = 1'b0;
        end
        if (wf) mq.push_back(int'(wr_data));
        @(negedge clk);
        check_outputs();
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_count"}, rcvd.size(), sent.size());
        for (int i = 0; i < sent.size() && i < rcvd.size(); i++) begin
            chk(tag, rcvd[i], sent[i]);
        end
        sent.delete();
        rcvd.delete();
    endtask

    initial begin
        int   nsent;
        bit   acc;
        bit   hold;
        logic [7:0] held;

        // Reset state
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Single word: visible two edges after the write edge
        wr_valid = 1'b1; wr_data = 8'hA5; rd_ready = 1'b1;
        cycle();
        chk("single_rv_n1", rd_valid, 1'b0);
        chk("single_lvl_n1", level, 5'd1);
        wr_valid = 1'b0;
        cycle();
        chk("single_rv_n2", rd_valid, 1'b1);
        chk("single_data", rd_data, 8'hA5);
        chk("single_lvl_n2", level, 5'd1);
        cycle();
        chk("single_lvl_n3", level, 5'd0);
        check_stream("single");

        // Fill to capacity with the consumer stalled
        rd_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wr_valid = 1'b1; wr_data = 8'(i);
            cycle();
        end
        chk("full_level", level, 5'd17);
        chk("full_wr_ready", wr_ready, 1'b0);
        wr_data = 8'h55;
        cycle();
        chk("full_reject_level", level, 5'd17);
        wr_valid = 1'b0;

        // Drain
        rd_ready = 1'b1;
        cycle();
        chk("drain_wr_ready", wr_ready, 1'b1);
        repeat (16) cycle();
        chk("drain_level", level, 5'd0);
        chk("drain_count", rcvd.size(), 17);
        check_stream("fill_drain");

        // Concurrent streaming across pointer wrap
        nsent = 0;
        for (int c = 0; c < 200 && (nsent < 40 || level != 0); c++) begin
            wr_valid = (nsent < 40);
            wr_data  = 8'(nsent);
            acc = wr_valid && wr_ready;
            cycle();
            if (acc) nsent++;
        end
        wr_valid = 1'b0;
        chk("stream_done", (nsent == 40) && (level == 0), 1'b1);
        check_stream("stream");

        // Random backpressure
        hold = 1'b0; held = 8'h00;
        for (int c = 0; c < 400; c++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_data  = 8'($urandom);
            rd_ready = 1'($urandom_range(0, 1));
            if (hold && rd_valid) chk("hold_data", rd_data, held);
            cycle();
            hold = rd_valid && !rd_ready;
            held = rd_data;
        end
        wr_valid = 1'b0; rd_ready = 1'b1;
        for (int c = 0; c < 40 && level != 0; c++) cycle();
        chk("bp_drained", level, 5'd0);
        check_stream("backpressure");

        // Asynchronous reset mid-burst
        rd_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr_valid = 1'b1; wr_data = 8'(8'h80 + i);
            cycle();
        end
        wr_valid = 1'b0;
        chk("pre_reset_level", level, 5'd9);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_level", level, 5'd0);
        chk("rst_wr_ready", wr_ready, 1'b1);
`ifdef FIFO_CTRL_ALMOST_EN
        chk("rst_almost_empty", almost_empty, 1'b1);
        chk("rst_almost_full", almost_full, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        wr_valid = 1'b1; wr_data = 8'h3C; rd_ready = 1'b1;
        cycle();
        wr_valid = 1'b0;
        repeat (3) cycle();
        chk("post_reset_count", rcvd.size(), 1);
        check_stream("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Synchronous first-in-first-out controller that sequences the 16×8 simple dual-port block RAM (`memory`) as a buffer between one producer and one consumer. It owns the write/read pointers, occupancy count and the RAM's `w_en`/`r_en` strobes. Both sides use a valid/ready handshake. It sits between a streaming source (e.g. UART RX) and a sink that can stall.

## Interface

**Parameters**
- `DATA_W`, 8: word width; passed to the RAM.
- `ADDR_W`, 4: RAM address width; depth `DEPTH = 2**ADDR_W`.
- `AF_LEVEL`, 12: almost-full threshold (used only with the macro).
- `AE_LEVEL`, 2: almost-empty threshold (used only with the macro).

**Ports**
- `clk`, in, 1: single clock; all logic rises on its posedge.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `wr_valid`, in, 1: producer offers `wr_data`.
- `wr_ready`, out, 1: controller accepts this cycle.
- `wr_data`, in, `DATA_W`: write word.
- `rd_valid`, out, 1: `rd_data` holds the head word.
- `rd_ready`, in, 1: consumer takes the head word.
- `rd_data`, out, `DATA_W`: head word; this is the RAM's registered `r_data`.
- `level`, out, `ADDR_W+1`: words held (RAM plus output stage), range 0..`DEPTH+1`.
- `almost_full`, out, 1: macro only.
- `almost_empty`, out, 1: macro only.

## Operation

- **Write fire:** `wr_valid && wr_ready`. The RAM write is `w_en=1`, `w_addr=wp`, then `wp++` and `mem_cnt++`.
- **`wr_ready`:** `wr_ready = (mem_cnt != DEPTH)`. It is a function of registered state only, with no combinational path from `rd_ready`.
- **Read fire:** `rd_valid && rd_ready`.
- **Output stage:** a one-bit state `out_valid` drives `rd_valid`. Its two states are EMPTY and VALID.
- **Read issue:** `issue = (mem_cnt != 0) && (!out_valid || rd_fire)`. On issue, `r_en=1`, `r_addr=rp`, then `rp++` and `mem_cnt--`.
- **Output-stage transitions:**
  - EMPTY→VALID on issue.
  - VALID→VALID on issue, or when neither fire nor issue occurs.
  - VALID→EMPTY on `rd_fire` without issue.
- **Pointers:** `wp` and `rp` are `ADDR_W` bits and wrap modulo `DEPTH` with no special case.
- **Counter update:** when write fire and issue occur in the same cycle, `mem_cnt` is unchanged.
- **Level:** `level = mem_cnt + out_valid`, registered.
- **Same-address read/write:** cannot occur. An issue only targets a slot whose write completed on an earlier edge.
- **Holding `rd_data`:** when `r_en=0` the RAM holds `r_data`, so `rd_data` is stable while `rd_valid && !rd_ready`.
- **Reset (any time, including mid-transfer):** `wp`, `rp`, `mem_cnt` and `out_valid` go to 0. `wr_ready=1`, `rd_valid=0`, `level=0`.
  - RAM contents and `rd_data` are not reset and are don't-care while `rd_valid=0`.
  - In-flight words are discarded.

## Timing

- **Write-to-read latency:** a word written on edge N (FIFO empty) is issued on edge N+1. `rd_valid` rises after edge N+1, and `rd_data` is valid in cycle N+2.
- **Throughput:** one write and one read per cycle sustained. No bubbles while `mem_cnt > 0` and `rd_ready=1`.
- **Full:** `wr_ready` falls the cycle after the write that makes `mem_cnt = DEPTH`. It rises the cycle after the next issue.
- **Capacity:** `DEPTH + 1` words (16 in RAM plus 1 in the output stage).

## Configuration

- **Macro:** `FIFO_CTRL_ALMOST_EN`.
- **Defined:**
  - `almost_full` is registered `level >= AF_LEVEL`.
  - `almost_empty` is registered `level <= AE_LEVEL`.
  - Both reset to 0 and 1 respectively and update on the same edge as `level`.
- **Undefined:** both ports and their logic are absent. `AF_LEVEL` and `AE_LEVEL` are unused.

## Structure

- **Package `fifo_ctrl_pkg`:** default `DATA_W` and `ADDR_W` constants, plus the output-stage state encoding `ST_EMPTY=1'b0`, `ST_VALID=1'b1`.
- **Sub-module:** one instance of the existing `memory` block, with ports wired to `w_en`, `r_en`, `w_addr`, `r_addr`, `w_data` and `r_data`. No other sub-modules.

## Test plan

- **Single word:** after reset, write 0xA5 with `rd_ready=1`.
  - `rd_valid` rises 2 cycles after the write edge with `rd_data=0xA5`.
  - `level` goes 0→1→1→0.
- **Fill:** hold `rd_ready=0` and write 0x00..0x10 (17 words).
  - All 17 are accepted.
  - `wr_ready=0` with `level=17`.
  - An 18th `wr_valid` is not accepted.
- **Drain:** then set `rd_ready=1`.
  - Reads 0x00..0x10 in order on 17 consecutive cycles.
  - `wr_ready` returns one cycle after the first issue.
- **Streaming and wrap:** write and read concurrently for 40 words, 0x00..0x27.
  - Pointers wrap at least twice.
  - Output order is exact, with no bubbles after the first valid.
- **Backpressure:** toggle `rd_ready` pseudo-randomly.
  - `rd_data` is stable while `rd_valid && !rd_ready`.
  - No loss or duplication.
- **Reset mid-operation:** assert `rst_n=0` mid-burst with `level=9` (and `FIFO_CTRL_ALMOST_EN` defined).
  - Immediately `rd_valid=0`, `level=0`, `wr_ready=1`, `almost_empty=1`.
  - A subsequent write of 0x3C reads back as 0x3C.
